hwpe_ctrl_regfile_mc: RTL and testbench
=======================================

# hwpe_ctrl_regfile_mc

Parametrised multi-context job register file for HWPE control slaves. It supersedes the fixed-context register file: N_CONTEXT contexts with explicit per-context state (FREE/OFFLOADING/QUEUED/RUNNING), requester-locked offload, round-robin job dispatch to the engine, a configurable job-ID width and a saturating finished counter. It sits between the peripheral target port and the engine FSM.

## Interface
- N_CONTEXT, 2: number of job contexts, ≥1, any value.
- N_IO_REGS, 8: 32-bit job registers per context.
- N_GENERIC_REGS, 0: shared, uncontexted 32-bit registers, 0..24.
- ID_WIDTH, 16: requester ID width.
- JOB_ID_WIDTH, 8: job-ID counter width, ≤30.
- FINISHED_MAX, 2: finished-counter saturation value, ≥1.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- clear_i  in  1  synchronous clear, same effect as reset.
- req_i  in  1  register access strobe; always accepted.
- wen_i  in  1  1 = write, 0 = read.
- addr_i  in  8  word address.
- wdata_i  in  32  write data.
- be_i  in  4  byte enables.
- id_i  in  ID_WIDTH  requester ID.
- r_valid_o  out  1  read data valid.
- r_data_o  out  32  read data.
- start_o  out  1  one-cycle job start pulse to the engine.
- done_i  in  1  one-cycle job completion pulse from the engine.
- busy_o  out  1  a context is RUNNING.
- evt_o  out  1  one-cycle completion event.
- running_ctx_o  out  $clog2(N_CONTEXT) or 1  index of the running/next context (run_q).
- params_o  out  N_IO_REGS×32  job registers of context run_q.
- generic_o  out  max(N_GENERIC_REGS,1)×32  generic registers; 0 if none.

## Operation
- Address map: 0x00 TRIGGER (W), 0x01 ACQUIRE (R), 0x02 FINISHED (R, clear-on-read), 0x03 STATUS (R), 0x04 RUNNING_JOB (R), 0x05 SOFT_CLEAR (W), 0x08+g generic g, 0x20+k job register k of context ptr_q. Any other read returns 0xDEADBEEF; any other write is dropped.
- Pointers: ptr_q (offload) and run_q (dispatch), both reset to 0 and incremented modulo N_CONTEXT.
- ACQUIRE read, in priority order:
  - any context OFFLOADING → 0xFFFFFFFE;
  - otherwise ctx[ptr_q]≠FREE → 0xFFFFFFFF;
  - otherwise return zero-extended job_id_q, set ctx[ptr_q]=OFFLOADING, latch owner=id_i, increment job_id_q (wraps at 2^JOB_ID_WIDTH).
- Job-register write: byte-enabled, applied only if ctx[ptr_q]==OFFLOADING and id_i==owner; otherwise dropped. Job-register reads return ctx[ptr_q] contents.
- TRIGGER write, any data: applied only under the same owner/OFFLOADING condition. Sets ctx[ptr_q]=QUEUED, ptr_q++, releases the lock.
- Dispatch: when no context is RUNNING and ctx[run_q]==QUEUED, pulse start_o and set ctx[run_q]=RUNNING.
- done_i while RUNNING:
  - ctx[run_q]=FREE, run_q++, running_job_q++;
  - finished counter increments, saturating at FINISHED_MAX;
  - evt_o pulses.
- done_i while not busy is ignored.
- STATUS: bit c = ctx[c]≠FREE; bit 31 = busy_o.
- RUNNING_JOB: zero-extended running_job_q.
- FINISHED read returns the count and clears it.
- SOFT_CLEAR write: on the following edge, identical to clear_i for one cycle.
- Generic registers are byte-enabled, writable by any requester at any time.
- Reset/clear: all contexts FREE; pointers, job IDs, counter, owner and register contents zero.

## Timing
- Reset values: r_valid_o=0, r_data_o=0, start_o=0, busy_o=0, evt_o=0, running_ctx_o=0, params_o=0, generic_o=0.
- Reads: r_valid_o and r_data_o registered, 1 cycle after req_i. Writes take effect on the request edge.
- Trigger-to-start: TRIGGER at edge T with engine idle → start_o high in cycle T+1, busy_o from T+2.
- done_i at edge T → evt_o high in cycle T+1. A queued successor gets start_o at T+2, never in the same cycle as evt_o.
- Simultaneous events: every access sees pre-edge state.
  - ACQUIRE in the same cycle as a done_i that frees ctx[ptr_q] still returns 0xFFFFFFFF.
  - FINISHED read with done_i in the same cycle returns the old count; the counter becomes 1 (clear, then increment).
  - TRIGGER with done_i in the same cycle: both are applied.
- Reset or clear mid-job drops all contexts. A later done_i is ignored.

## Test plan
- Reset → r_data_o=0, STATUS read=0x00000000, ACQUIRE by id 3 returns 0x00000000, STATUS=0x00000001.
- Id 3 acquires, writes 0x20=0xCAFEF00D with be=0x3, triggers → start_o one cycle later; params_o[0]=0x0000F00D; done_i → evt_o, FINISHED read=1, second FINISHED read=0.
- Id 3 acquires; id 5 ACQUIRE returns 0xFFFFFFFE; id 5 writes to 0x20 and TRIGGER are dropped, no start_o.
- N_CONTEXT=2: two acquire/trigger cycles with the engine held busy → third ACQUIRE returns 0xFFFFFFFF; after done_i, ACQUIRE returns job ID 2 and the second job starts automatically.
- JOB_ID_WIDTH=2: five complete jobs → fifth ACQUIRE returns 0x00000000 (wrap); three done_i with no FINISHED read → FINISHED=2 (saturation).
- Assert rst_ni mid-RUNNING → all outputs zero asynchronously; after release, done_i → no evt_o; SOFT_CLEAR write while QUEUED → STATUS=0 two cycles later.

Source files
------------

// File: rtl/hwpe_ctrl_regfile_mc.sv
// hwpe_ctrl_regfile_mc: multi-context job register file for HWPE control slaves.
// Contexts are offloaded through ptr_q and dispatched round-robin through run_q.
module hwpe_ctrl_regfile_mc #(
  parameter int unsigned N_CONTEXT      = 2,
  parameter int unsigned N_IO_REGS      = 8,
  parameter int unsigned N_GENERIC_REGS = 0,
  parameter int unsigned ID_WIDTH       = 16,
  parameter int unsigned JOB_ID_WIDTH   = 8,
  parameter int unsigned FINISHED_MAX   = 2,
  localparam int unsigned PW = (N_CONTEXT > 1) ? $clog2(N_CONTEXT) : 1,
  localparam int unsigned GW = (N_GENERIC_REGS > 0) ? N_GENERIC_REGS : 1
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          clear_i,
  input  logic                          req_i,
  input  logic                          wen_i,
  input  logic [7:0]                    addr_i,
  input  logic [31:0]                   wdata_i,
  input  logic [3:0]                    be_i,
  input  logic [ID_WIDTH-1:0]           id_i,
  output logic                          r_valid_o,
  output logic [31:0]                   r_data_o,
  output logic                          start_o,
  input  logic                          done_i,
  output logic                          busy_o,
  output logic                          evt_o,
  output logic [PW-1:0]                 running_ctx_o,
  output logic [N_IO_REGS-1:0][31:0]    params_o,
  output logic [GW-1:0][31:0]           generic_o
);
  localparam int unsigned FW       = $clog2(FINISHED_MAX + 1);
  localparam int unsigned GEN_BASE = 8;
  localparam int unsigned JOB_BASE = 32;

  localparam logic [7:0] ADDR_TRIGGER     = 8'h00;
  localparam logic [7:0] ADDR_ACQUIRE     = 8'h01;
  localparam logic [7:0] ADDR_FINISHED    = 8'h02;
  localparam logic [7:0] ADDR_STATUS      = 8'h03;
  localparam logic [7:0] ADDR_RUNNING_JOB = 8'h04;
  localparam logic [7:0] ADDR_SOFT_CLEAR  = 8'h05;

  typedef enum logic [1:0] {CTX_FREE, CTX_OFFLOADING, CTX_QUEUED, CTX_RUNNING} ctx_state_e;

  ctx_state_e                              ctx_q [N_CONTEXT];
  ctx_state_e                              ctx_d [N_CONTEXT];
  logic [N_CONTEXT-1:0][N_IO_REGS-1:0][31:0] regs_q, regs_d;
  logic [GW-1:0][31:0]                     gen_q, gen_d;
  logic [PW-1:0]                           ptr_q, ptr_d, run_q, run_d;
  logic [ID_WIDTH-1:0]                     owner_q, owner_d;
  logic [JOB_ID_WIDTH-1:0]                 job_id_q, job_id_d, running_job_q, running_job_d;
  logic [FW-1:0]                           fin_q, fin_d;
  logic                                    evt_q, evt_d, soft_clr_q, soft_clr_d;
  logic                                    r_valid_q, r_valid_d;
  logic [31:0]                             r_data_q, r_data_d;

  ctx_state_e                 ptr_st, run_st;
  logic                       busy, any_offl, own_ok, dispatch, done_ok, clear;
  logic [N_IO_REGS-1:0][31:0] run_regs;

  function automatic logic [31:0] be_merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                           input logic [3:0] be);
    logic [31:0] r;
    for (int unsigned b = 0; b < 4; b++)
      r[8*b +: 8] = be[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
    return r;
  endfunction

  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
    return (p == PW'(N_CONTEXT - 1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    busy     = 1'b0;
    any_offl = 1'b0;
    ptr_st   = CTX_FREE;
    run_st   = CTX_FREE;
    run_regs = '0;
    for (int unsigned c = 0; c < N_CONTEXT; c++) begin
      if (ctx_q[c] == CTX_RUNNING)    busy = 1'b1;
      if (ctx_q[c] == CTX_OFFLOADING) any_offl = 1'b1;
      if (ptr_q == PW'(c)) ptr_st = ctx_q[c];
      if (run_q == PW'(c)) begin
        run_st   = ctx_q[c];
        run_regs = regs_q[c];
      end
    end
  end

  assign clear    = clear_i | soft_clr_q;
  assign own_ok   = (ptr_st == CTX_OFFLOADING) && (id_i == owner_q);
  // Holding dispatch while evt_q is high keeps a successor's start off the evt cycle.
  assign dispatch = !busy && (run_st == CTX_QUEUED) && !evt_q && !clear;
  assign done_ok  = done_i && busy;

  always_comb begin
    ctx_d         = ctx_q;
    regs_d        = regs_q;
    gen_d         = gen_q;
    ptr_d         = ptr_q;
    run_d         = run_q;
    owner_d       = owner_q;
    job_id_d      = job_id_q;
    running_job_d = running_job_q;
    fin_d         = fin_q;
    evt_d         = 1'b0;
    soft_clr_d    = 1'b0;
    r_valid_d     = 1'b0;
    r_data_d      = r_data_q;

    if (dispatch)
      for (int unsigned c = 0; c < N_CONTEXT; c++)
        if (run_q == PW'(c)) ctx_d[c] = CTX_RUNNING;

    if (req_i && !wen_i) begin
      r_valid_d = 1'b1;
      r_data_d  = 32'hDEADBEEF;
      case (addr_i)
        ADDR_ACQUIRE: begin
          if (any_offl)                r_data_d = 32'hFFFF_FFFE;
          else if (ptr_st != CTX_FREE) r_data_d = 32'hFFFF_FFFF;
          else begin
            r_data_d = 32'(job_id_q);
            job_id_d = job_id_q + JOB_ID_WIDTH'(1);
            owner_d  = id_i;
            for (int unsigned c = 0; c < N_CONTEXT; c++)
              if (ptr_q == PW'(c)) ctx_d[c] = CTX_OFFLOADING;
          end
        end
        ADDR_FINISHED: begin
          r_data_d = 32'(fin_q);
          fin_d    = '0;
        end
        ADDR_STATUS: begin
          r_data_d     = '0;
          r_data_d[31] = busy;
          for (int unsigned c = 0; c < N_CONTEXT && c < 31; c++)
            r_data_d[c] = (ctx_q[c] != CTX_FREE);
        end
        ADDR_RUNNING_JOB: r_data_d = 32'(running_job_q);
        default: begin
          for (int unsigned g = 0; g < N_GENERIC_REGS; g++)
            if ({24'b0, addr_i} == GEN_BASE + g) r_data_d = gen_q[g];
          for (int unsigned k = 0; k < N_IO_REGS; k++)
            if ({24'b0, addr_i} == JOB_BASE + k)
              for (int unsigned c = 0; c < N_CONTEXT; c++)
                if (ptr_q == PW'(c)) r_data_d = regs_q[c][k];
        end
      endcase
    end

    if (req_i && wen_i) begin
      case (addr_i)
        ADDR_TRIGGER: if (own_ok) begin
          ptr_d = wrap_inc(ptr_q);
          for (int unsigned c = 0; c < N_CONTEXT; c++)
            if (ptr_q == PW'(c)) ctx_d[c] = CTX_QUEUED;
        end
        ADDR_SOFT_CLEAR: soft_clr_d = 1'b1;
        default: begin
          for (int unsigned g = 0; g < N_GENERIC_REGS; g++)
            if ({24'b0, addr_i} == GEN_BASE + g) gen_d[g] = be_merge(gen_q[g], wdata_i, be_i);
          for (int unsigned k = 0; k < N_IO_REGS; k++)
            if (own_ok && {24'b0, addr_i} == JOB_BASE + k)
              for (int unsigned c = 0; c < N_CONTEXT; c++)
                if (ptr_q == PW'(c)) regs_d[c][k] = be_merge(regs_q[c][k], wdata_i, be_i);
        end
      endcase
    end

    // Applied after the FINISHED read so a same-cycle read clears before counting.
    if (done_ok) begin
      for (int unsigned c = 0; c < N_CONTEXT; c++)
        if (run_q == PW'(c)) ctx_d[c] = CTX_FREE;
      run_d         = wrap_inc(run_q);
      running_job_d = running_job_q + JOB_ID_WIDTH'(1);
      if (fin_d < FW'(FINISHED_MAX)) fin_d = fin_d + FW'(1);
      evt_d = 1'b1;
    end

    if (clear) begin
      for (int unsigned c = 0; c < N_CONTEXT; c++) ctx_d[c] = CTX_FREE;
      regs_d        = '0;
      gen_d         = '0;
      ptr_d         = '0;
      run_d         = '0;
      owner_d       = '0;
      job_id_d      = '0;
      running_job_d = '0;
      fin_d         = '0;
      evt_d         = 1'b0;
      soft_clr_d    = 1'b0;
      r_valid_d     = 1'b0;
      r_data_d      = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned c = 0; c < N_CONTEXT; c++) ctx_q[c] <= CTX_FREE;
      regs_q        <= '0;
      gen_q         <= '0;
      ptr_q         <= '0;
      run_q         <= '0;
      owner_q       <= '0;
      job_id_q      <= '0;
      running_job_q <= '0;
      fin_q         <= '0;
      evt_q         <= 1'b0;
      soft_clr_q    <= 1'b0;
      r_valid_q     <= 1'b0;
      r_data_q      <= '0;
    end else begin
      ctx_q         <= ctx_d;
      regs_q        <= regs_d;
      gen_q         <= gen_d;
      ptr_q         <= ptr_d;
      run_q         <= run_d;
      owner_q       <= owner_d;
      job_id_q      <= job_id_d;
      running_job_q <= running_job_d;
      fin_q         <= fin_d;
      evt_q         <= evt_d;
      soft_clr_q    <= soft_clr_d;
      r_valid_q     <= r_valid_d;
      r_data_q      <= r_data_d;
    end
  end

  assign r_valid_o     = r_valid_q;
  assign r_data_o      = r_data_q;
  assign start_o       = dispatch;
  assign busy_o        = busy;
  assign evt_o         = evt_q;
  assign running_ctx_o = run_q;
  assign params_o      = run_regs;
  assign generic_o     = gen_q;

endmodule

// File: tb/tb_hwpe_ctrl_regfile_mc.sv
// Scoreboard bench for hwpe_ctrl_regfile_mc: reads are queued with expected data
// and checked by a monitor; control outputs are checked at fixed cycle offsets.
`timescale 1ns/1ps
module tb_hwpe_ctrl_regfile_mc;
  localparam int unsigned N_CONTEXT      = 2;
  localparam int unsigned N_IO_REGS      = 8;
  localparam int unsigned N_GENERIC_REGS = 2;
  localparam int unsigned ID_WIDTH       = 16;
  localparam int unsigned JOB_ID_WIDTH   = 2;
  localparam int unsigned FINISHED_MAX   = 2;

  logic clk = 1'b0, rst_n = 1'b0, clear = 1'b0, req = 1'b0, wen = 1'b0, done = 1'b0;
  logic [7:0]  addr  = '0;
  logic [31:0] wdata = '0;
  logic [3:0]  be    = '0;
  logic [ID_WIDTH-1:0] id = '0;
  logic r_valid, start, busy, evt;
  logic [31:0] r_data;
  logic [0:0]  running_ctx;
  logic [N_IO_REGS-1:0][31:0]      params;
  logic [N_GENERIC_REGS-1:0][31:0] generic;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];
  string       name_q[$];

  always #5 clk = ~clk;

  hwpe_ctrl_regfile_mc #(
    .N_CONTEXT(N_CONTEXT), .N_IO_REGS(N_IO_REGS), .N_GENERIC_REGS(N_GENERIC_REGS),
    .ID_WIDTH(ID_WIDTH), .JOB_ID_WIDTH(JOB_ID_WIDTH), .FINISHED_MAX(FINISHED_MAX)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .req_i(req), .wen_i(wen),
    .addr_i(addr), .wdata_i(wdata), .be_i(be), .id_i(id),
    .r_valid_o(r_valid), .r_data_o(r_data), .start_o(start), .done_i(done),
    .busy_o(busy), .evt_o(evt), .running_ctx_o(running_ctx),
    .params_o(params), .generic_o(generic)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (r_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rvalid: got 0x%08h expected no read", r_data);
      end else begin
        logic [31:0] e;
        string nm;
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        chk(nm, r_data, e);
      end
    end
  end

  task automatic rd(input logic [7:0] a, input logic [ID_WIDTH-1:0] i, input logic [31:0] e,
                    input string nm);
    req = 1'b1; wen = 1'b0; addr = a; id = i;
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(posedge clk); #1;
    req = 1'b0;
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] b,
                    input logic [ID_WIDTH-1:0] i);
    req = 1'b1; wen = 1'b1; addr = a; wdata = d; be = b; id = i;
    @(posedge clk); #1;
    req = 1'b0; wen = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic pulse_done();
    done = 1'b1;
    @(posedge clk); #1;
    done = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    // reset values
    @(negedge clk);
    chk("rst_r_valid", 32'(r_valid), 0);
    chk("rst_r_data", r_data, 0);
    chk("rst_start", 32'(start), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_evt", 32'(evt), 0);
    chk("rst_running_ctx", 32'(running_ctx), 0);
    chk("rst_params0", params[0], 0);
    chk("rst_generic0", generic[0], 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    rd(8'h03, 16'd3, 32'h0000_0000, "status_idle");
    rd(8'h01, 16'd3, 32'h0000_0000, "acquire_first");
    rd(8'h03, 16'd3, 32'h0000_0001, "status_offloading");
    rd(8'h06, 16'd3, 32'hDEAD_BEEF, "unmapped_read");
    wr(8'h08, 32'hAABB_CCDD, 4'h5, 16'd7);
    chk("generic0_out", generic[0], 32'h00BB_00DD);
    rd(8'h08, 16'd1, 32'h00BB_00DD, "generic0_read");

    // single job, byte-enabled write, start/evt timing
    wr(8'h20, 32'hCAFE_F00D, 4'h3, 16'd3);
    rd(8'h20, 16'd3, 32'h0000_F00D, "jobreg_readback");
    wr(8'h00, 32'h0, 4'hF, 16'd3);
    @(negedge clk);
    chk("trig_start", 32'(start), 1);
    chk("trig_busy_early", 32'(busy), 0);
    chk("trig_params0", params[0], 32'h0000_F00D);
    @(posedge clk); #1;
    @(negedge clk);
    chk("start_single", 32'(start), 0);
    chk("busy_running", 32'(busy), 1);
    pulse_done();
    @(negedge clk);
    chk("done_evt", 32'(evt), 1);
    chk("done_busy", 32'(busy), 0);
    rd(8'h02, 16'd3, 32'h0000_0001, "finished_one");
    rd(8'h02, 16'd3, 32'h0000_0000, "finished_cleared");

    // requester lock
    rd(8'h01, 16'd3, 32'h0000_0001, "acquire_id3");
    rd(8'h01, 16'd5, 32'hFFFF_FFFE, "acquire_locked");
    wr(8'h20, 32'h1234_5678, 4'hF, 16'd5);
    rd(8'h20, 16'd5, 32'h0000_0000, "foreign_write_dropped");
    wr(8'h00, 32'h0, 4'hF, 16'd5);
    @(negedge clk);
    chk("foreign_trigger_nostart", 32'(start), 0);
    idle(1);
    @(negedge clk);
    chk("foreign_trigger_nobusy", 32'(busy), 0);
    rd(8'h03, 16'd5, 32'h0000_0002, "status_ctx1_offl");

    // two contexts queued behind a busy engine
    wr(8'h00, 32'h0, 4'hF, 16'd3);
    @(negedge clk);
    chk("ctx1_start", 32'(start), 1);
    chk("ctx1_running_ctx", 32'(running_ctx), 1);
    rd(8'h01, 16'd3, 32'h0000_0002, "acquire_while_busy");
    wr(8'h00, 32'h0, 4'hF, 16'd3);
    rd(8'h01, 16'd3, 32'hFFFF_FFFF, "acquire_full");
    rd(8'h03, 16'd3, 32'h8000_0003, "status_run_queued");
    pulse_done();
    @(negedge clk);
    chk("chain_evt", 32'(evt), 1);
    chk("chain_nostart_with_evt", 32'(start), 0);
    @(negedge clk);
    chk("chain_successor_start", 32'(start), 1);
    chk("chain_evt_gone", 32'(evt), 0);
    chk("chain_running_ctx", 32'(running_ctx), 0);
    rd(8'h01, 16'd3, 32'h0000_0003, "acquire_after_free");
    rd(8'h03, 16'd3, 32'h8000_0003, "status_run_offl");
    rd(8'h04, 16'd3, 32'h0000_0002, "running_job_two");
    wr(8'h00, 32'h0, 4'hF, 16'd3);

    // simultaneous events see pre-edge state
    done = 1'b1;
    rd(8'h01, 16'd3, 32'hFFFF_FFFF, "acquire_with_done");
    done = 1'b0;
    idle(3);
    done = 1'b1;
    rd(8'h02, 16'd3, 32'h0000_0002, "finished_with_done");
    done = 1'b0;
    rd(8'h02, 16'd3, 32'h0000_0001, "finished_after_clear_inc");
    rd(8'h04, 16'd3, 32'h0000_0000, "running_job_wrap");
    rd(8'h03, 16'd3, 32'h0000_0000, "status_all_free");

    // job-ID wrap and finished-counter saturation
    for (int j = 0; j < 3; j++) begin
      rd(8'h01, 16'd3, 32'(j), "acquire_wrap_seq");
      wr(8'h00, 32'h0, 4'hF, 16'd3);
      idle(2);
      pulse_done();
      idle(2);
    end
    rd(8'h02, 16'd3, 32'h0000_0002, "finished_saturated");
    rd(8'h02, 16'd3, 32'h0000_0000, "finished_sat_cleared");

    // async reset mid-job
    rd(8'h01, 16'd3, 32'h0000_0003, "acquire_before_reset");
    wr(8'h21, 32'h1122_3344, 4'hF, 16'd3);
    wr(8'h00, 32'h0, 4'hF, 16'd3);
    idle(2);
    @(negedge clk);
    chk("prereset_busy", 32'(busy), 1);
    chk("prereset_running_ctx", 32'(running_ctx), 1);
    chk("prereset_params1", params[1], 32'h1122_3344);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_busy", 32'(busy), 0);
    chk("async_rst_running_ctx", 32'(running_ctx), 0);
    chk("async_rst_params1", params[1], 0);
    chk("async_rst_generic0", generic[0], 0);
    chk("async_rst_start", 32'(start), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    pulse_done();
    @(negedge clk);
    chk("stale_done_no_evt", 32'(evt), 0);
    rd(8'h03, 16'd3, 32'h0000_0000, "status_after_reset");

    // soft clear while a context is queued
    rd(8'h01, 16'd3, 32'h0000_0000, "acquire_post_reset");
    wr(8'h00, 32'h0, 4'hF, 16'd3);
    rd(8'h01, 16'd3, 32'h0000_0001, "acquire_second_post_reset");
    wr(8'h00, 32'h0, 4'hF, 16'd3);
    rd(8'h03, 16'd3, 32'h8000_0003, "status_before_soft_clear");
    wr(8'h05, 32'h0, 4'hF, 16'd9);
    idle(1);
    rd(8'h03, 16'd3, 32'h0000_0000, "status_after_soft_clear");
    chk("soft_clear_busy", 32'(busy), 0);
    rd(8'h01, 16'd3, 32'h0000_0000, "acquire_after_soft_clear");

    // external synchronous clear
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    rd(8'h03, 16'd3, 32'h0000_0000, "status_after_clear");
    rd(8'h01, 16'd3, 32'h0000_0000, "acquire_after_clear");

    idle(2);
    chk("scoreboard_drained", 32'(exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
